// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared types and register map defaults for the TPL DAC profile sequencer.
package ad_ip_jesd204_tpl_dac_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_RST_LO,
      S_PROF,
      S_SEL,
      S_RST_HI,
      S_RDBK,
      S_FIN
   } seq_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_MISMATCH = 2'd2;

   localparam logic [10:0] DEF_RSTN_ADDR       = 11'h010;
   localparam logic [10:0] DEF_PROFILE_ADDR    = 11'h091;
   localparam logic [10:0] DEF_CHAN_BASE       = 11'h100;
   localparam logic [10:0] DEF_DATA_SEL_OFFSET = 11'h006;

   // Values written to the common reset register: hold in reset / release.
   localparam logic [31:0] RSTN_ASSERT  = 32'h0;
   localparam logic [31:0] RSTN_RELEASE = 32'h3;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_up_txn.sv
// Single up_* bus transaction engine: one registered request pulse, then wait
// for the matching ack or give up after TIMEOUT cycles.
module ad_ip_jesd204_tpl_dac_up_txn #(
   parameter int TIMEOUT = 255
) (
   input  logic        up_clk,
   input  logic        up_rst,
   input  logic        start,
   input  logic        start_wr,
   input  logic [10:0] start_addr,
   input  logic [31:0] start_wdata,
   output logic        done_wr,
   output logic        done_rd,
   output logic        timeout,
   output logic [31:0] rdata,
   output logic        m_up_wreq,
   output logic [10:0] m_up_waddr,
   output logic [31:0] m_up_wdata,
   input  logic        m_up_wack,
   output logic        m_up_rreq,
   output logic [10:0] m_up_raddr,
   input  logic [31:0] m_up_rdata,
   input  logic        m_up_rack
);

   logic       busy;
   logic       wr_q;
   logic [7:0] cnt;

   // Acks are only honoured while a transaction of the same type is open.
   assign done_wr = busy &  wr_q & m_up_wack;
   assign done_rd = busy & ~wr_q & m_up_rack;
   assign timeout = busy & ~(done_wr | done_rd) & (cnt == 8'(TIMEOUT));
   assign rdata   = m_up_rdata;

   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         busy       <= 1'b0;
         wr_q       <= 1'b0;
         cnt        <= 8'd0;
         m_up_wreq  <= 1'b0;
         m_up_rreq  <= 1'b0;
         m_up_waddr <= 11'd0;
         m_up_wdata <= 32'd0;
         m_up_raddr <= 11'd0;
      end else begin
         m_up_wreq <= 1'b0;
         m_up_rreq <= 1'b0;
         if (start) begin
            busy      <= 1'b1;
            wr_q      <= start_wr;
            cnt       <= 8'd0;
            m_up_wreq <= start_wr;
            m_up_rreq <= ~start_wr;
            if (start_wr) begin
               m_up_waddr <= start_addr;
               m_up_wdata <= start_wdata;
            end else begin
               m_up_raddr <= start_addr;
            end
         end else if (busy) begin
            if (done_wr | done_rd | timeout) begin
               busy <= 1'b0;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_profile_seq.sv
// Profile-switch sequencer mastering the up_* bus in front of the TPL DAC
// regmap; external accesses pass through when idle and are buffered otherwise.
module ad_ip_jesd204_tpl_dac_profile_seq
   import ad_ip_jesd204_tpl_dac_pkg::*;
#(
   parameter int          NUM_CHANNELS    = 2,
   parameter int          NUM_PROFILES    = 1,
   parameter logic [10:0] RSTN_ADDR       = DEF_RSTN_ADDR,
   parameter logic [10:0] PROFILE_ADDR    = DEF_PROFILE_ADDR,
   parameter logic [10:0] CHAN_BASE       = DEF_CHAN_BASE,
   parameter logic [10:0] DATA_SEL_OFFSET = DEF_DATA_SEL_OFFSET,
   parameter int          TIMEOUT         = 255,
   localparam int         PW              = $clog2(NUM_PROFILES) + 1
) (
   input  logic                      up_clk,
   input  logic                      up_rst,
   input  logic                      seq_req,
   input  logic [PW-1:0]             seq_profile,
   input  logic [NUM_CHANNELS*4-1:0] seq_data_sel,
   output logic                      seq_busy,
   output logic                      seq_done,
   output logic                      seq_error,
   output logic [1:0]                seq_error_code,
   input  logic                      s_up_wreq,
   input  logic [10:0]               s_up_waddr,
   input  logic [31:0]               s_up_wdata,
   output logic                      s_up_wack,
   input  logic                      s_up_rreq,
   input  logic [10:0]               s_up_raddr,
   output logic [31:0]               s_up_rdata,
   output logic                      s_up_rack,
   output logic                      m_up_wreq,
   output logic [10:0]               m_up_waddr,
   output logic [31:0]               m_up_wdata,
   input  logic                      m_up_wack,
   output logic                      m_up_rreq,
   output logic [10:0]               m_up_raddr,
   input  logic [31:0]               m_up_rdata,
   input  logic                      m_up_rack
);

   seq_state_t state, state_next;

   logic [PW-1:0]             prof_q;
   logic [NUM_CHANNELS*4-1:0] sel_q;
   logic                      seq_pend;
   logic [5:0]                ch_cnt, ch_next;

   logic        wr_valid, rd_valid;
   logic [10:0] wr_addr, rd_addr;
   logic [31:0] wr_data;

   logic        txn_start, txn_wr;
   logic [10:0] txn_addr;
   logic [31:0] txn_wdata;
   logic        txn_wdone, txn_rdone, txn_tmo;
   logic [31:0] txn_rdata;

   logic        seq_accept, fin_err;
   logic [1:0]  fin_code;
   logic        wr_from_slot, wr_from_new, rd_from_slot, rd_from_new;

   function automatic logic [10:0] sel_addr(input logic [5:0] ch);
      return CHAN_BASE + {1'b0, ch, 4'b0000} + DATA_SEL_OFFSET;
   endfunction

   function automatic logic [31:0] sel_word(input logic [NUM_CHANNELS*4-1:0] sel,
                                            input logic [5:0] ch);
      logic [NUM_CHANNELS*4-1:0] sh;
      sh = sel >> {ch, 2'b00};
      return {28'd0, sh[3:0]};
   endfunction

   ad_ip_jesd204_tpl_dac_up_txn #(.TIMEOUT(TIMEOUT)) i_txn (
      .up_clk      (up_clk),
      .up_rst      (up_rst),
      .start       (txn_start),
      .start_wr    (txn_wr),
      .start_addr  (txn_addr),
      .start_wdata (txn_wdata),
      .done_wr     (txn_wdone),
      .done_rd     (txn_rdone),
      .timeout     (txn_tmo),
      .rdata       (txn_rdata),
      .m_up_wreq   (m_up_wreq),
      .m_up_waddr  (m_up_waddr),
      .m_up_wdata  (m_up_wdata),
      .m_up_wack   (m_up_wack),
      .m_up_rreq   (m_up_rreq),
      .m_up_raddr  (m_up_raddr),
      .m_up_rdata  (m_up_rdata),
      .m_up_rack   (m_up_rack)
   );

   assign s_up_wack  = (state == S_EXT) & txn_wdone;
   assign s_up_rack  = (state == S_EXT) & txn_rdone;
   assign s_up_rdata = s_up_rack ? txn_rdata : 32'd0;

   always_comb begin
      state_next   = state;
      ch_next      = ch_cnt;
      txn_start    = 1'b0;
      txn_wr       = 1'b0;
      txn_addr     = 11'd0;
      txn_wdata    = 32'd0;
      seq_accept   = 1'b0;
      fin_err      = 1'b0;
      fin_code     = ERR_NONE;
      wr_from_slot = 1'b0;
      wr_from_new  = 1'b0;
      rd_from_slot = 1'b0;
      rd_from_new  = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (seq_req || seq_pend) begin
               seq_accept = 1'b1;
               state_next = S_RST_LO;
               txn_start  = 1'b1;
               txn_wr     = 1'b1;
               txn_addr   = RSTN_ADDR;
               txn_wdata  = RSTN_ASSERT;
            end else if (wr_valid || s_up_wreq) begin
               wr_from_slot = wr_valid;
               wr_from_new  = ~wr_valid;
               state_next   = S_EXT;
               txn_start    = 1'b1;
               txn_wr       = 1'b1;
               txn_addr     = wr_valid ? wr_addr : s_up_waddr;
               txn_wdata    = wr_valid ? wr_data : s_up_wdata;
            end else if (rd_valid || s_up_rreq) begin
               rd_from_slot = rd_valid;
               rd_from_new  = ~rd_valid;
               state_next   = S_EXT;
               txn_start    = 1'b1;
               txn_addr     = rd_valid ? rd_addr : s_up_raddr;
            end
         end
         S_EXT: begin
            if (txn_wdone || txn_rdone || txn_tmo) state_next = S_IDLE;
         end
         S_RST_LO: begin
            if (txn_wdone) begin
               state_next = S_PROF;
               txn_start  = 1'b1;
               txn_wr     = 1'b1;
               txn_addr   = PROFILE_ADDR;
               txn_wdata  = 32'(prof_q);
            end
         end
         S_PROF: begin
            if (txn_wdone) begin
               state_next = S_SEL;
               ch_next    = 6'd0;
               txn_start  = 1'b1;
               txn_wr     = 1'b1;
               txn_addr   = sel_addr(6'd0);
               txn_wdata  = sel_word(sel_q, 6'd0);
            end
         end
         S_SEL: begin
            if (txn_wdone) begin
               txn_start = 1'b1;
               txn_wr    = 1'b1;
               if (ch_cnt == 6'(NUM_CHANNELS - 1)) begin
                  state_next = S_RST_HI;
                  txn_addr   = RSTN_ADDR;
                  txn_wdata  = RSTN_RELEASE;
               end else begin
                  ch_next   = ch_cnt + 6'd1;
                  txn_addr  = sel_addr(ch_cnt + 6'd1);
                  txn_wdata = sel_word(sel_q, ch_cnt + 6'd1);
               end
            end
         end
         S_RST_HI: begin
            if (txn_wdone) begin
               state_next = S_RDBK;
               txn_start  = 1'b1;
               txn_addr   = PROFILE_ADDR;
            end
         end
         S_RDBK: begin
            if (txn_rdone) begin
               state_next = S_FIN;
               if (txn_rdata[PW-1:0] != prof_q) begin
                  fin_err  = 1'b1;
                  fin_code = ERR_MISMATCH;
               end
            end
         end
         S_FIN: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      // A stalled regmap aborts the sequence without releasing DAC reset.
      if (txn_tmo && (state inside {S_RST_LO, S_PROF, S_SEL, S_RST_HI, S_RDBK})) begin
         state_next = S_FIN;
         txn_start  = 1'b0;
         fin_err    = 1'b1;
         fin_code   = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         state          <= S_IDLE;
         ch_cnt         <= 6'd0;
         prof_q         <= '0;
         sel_q          <= '0;
         seq_pend       <= 1'b0;
         seq_busy       <= 1'b0;
         seq_done       <= 1'b0;
         seq_error      <= 1'b0;
         seq_error_code <= ERR_NONE;
         wr_valid       <= 1'b0;
         wr_addr        <= 11'd0;
         wr_data        <= 32'd0;
         rd_valid       <= 1'b0;
         rd_addr        <= 11'd0;
      end else begin
         state    <= state_next;
         ch_cnt   <= ch_next;
         seq_done <= (state == S_FIN);

         if (seq_accept) begin
            seq_busy       <= 1'b1;
            seq_error      <= 1'b0;
            seq_error_code <= ERR_NONE;
            seq_pend       <= 1'b0;
            if (!seq_pend) begin
               prof_q <= seq_profile;
               sel_q  <= seq_data_sel;
            end
         end else if (state == S_EXT && seq_req && !seq_pend) begin
            seq_pend <= 1'b1;
            prof_q   <= seq_profile;
            sel_q    <= seq_data_sel;
         end

         if (state == S_FIN) seq_busy <= 1'b0;
         if (fin_err) begin
            seq_error      <= 1'b1;
            seq_error_code <= fin_code;
         end

         // One-deep slots; a request finding its slot occupied is dropped.
         if (s_up_wreq && !wr_from_new && (!wr_valid || wr_from_slot)) begin
            wr_valid <= 1'b1;
            wr_addr  <= s_up_waddr;
            wr_data  <= s_up_wdata;
         end else if (wr_from_slot) begin
            wr_valid <= 1'b0;
         end

         if (s_up_rreq && !rd_from_new && (!rd_valid || rd_from_slot)) begin
            rd_valid <= 1'b1;
            rd_addr  <= s_up_raddr;
         end else if (rd_from_slot) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_profile_seq.sv
// Bench for the profile sequencer: regmap model with configurable ack
// latency, expected-transaction queue built from the register map rules.
module tb_ad_ip_jesd204_tpl_dac_profile_seq;

   localparam int NCH = 2;
   localparam int PW  = 1;

   logic              up_clk = 1'b0;
   logic              up_rst = 1'b1;
   logic              seq_req = 1'b0;
   logic [PW-1:0]     seq_profile = '0;
   logic [NCH*4-1:0]  seq_data_sel = '0;
   logic              seq_busy, seq_done, seq_error;
   logic [1:0]        seq_error_code;
   logic              s_up_wreq = 1'b0;
   logic [10:0]       s_up_waddr = '0;
   logic [31:0]       s_up_wdata = '0;
   logic              s_up_wack;
   logic              s_up_rreq = 1'b0;
   logic [10:0]       s_up_raddr = '0;
   logic [31:0]       s_up_rdata;
   logic              s_up_rack;
   logic              m_up_wreq;
   logic [10:0]       m_up_waddr;
   logic [31:0]       m_up_wdata;
   logic              m_up_wack = 1'b0;
   logic              m_up_rreq;
   logic [10:0]       m_up_raddr;
   logic [31:0]       m_up_rdata = '0;
   logic              m_up_rack = 1'b0;

   always #5 up_clk = ~up_clk;

   ad_ip_jesd204_tpl_dac_profile_seq #(.NUM_CHANNELS(NCH), .NUM_PROFILES(1)) dut (
      .up_clk         (up_clk),
      .up_rst         (up_rst),
      .seq_req        (seq_req),
      .seq_profile    (seq_profile),
      .seq_data_sel   (seq_data_sel),
      .seq_busy       (seq_busy),
      .seq_done       (seq_done),
      .seq_error      (seq_error),
      .seq_error_code (seq_error_code),
      .s_up_wreq      (s_up_wreq),
      .s_up_waddr     (s_up_waddr),
      .s_up_wdata     (s_up_wdata),
      .s_up_wack      (s_up_wack),
      .s_up_rreq      (s_up_rreq),
      .s_up_raddr     (s_up_raddr),
      .s_up_rdata     (s_up_rdata),
      .s_up_rack      (s_up_rack),
      .m_up_wreq      (m_up_wreq),
      .m_up_waddr     (m_up_waddr),
      .m_up_wdata     (m_up_wdata),
      .m_up_wack      (m_up_wack),
      .m_up_rreq      (m_up_rreq),
      .m_up_raddr     (m_up_raddr),
      .m_up_rdata     (m_up_rdata),
      .m_up_rack      (m_up_rack)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge up_clk) cyc <= cyc + 1;

   // Regmap model: logs every request as {wr, addr, data}, acks after lat cycles.
   int          lat = 2;
   logic        drop_en = 1'b0;
   logic [10:0] drop_addr = 11'h091;
   logic        rd_ovr_en = 1'b0;
   logic [31:0] rd_ovr_val = '0;
   int          inject_req = 0;
   int          inject_done = 0;
   logic [31:0] mem [0:2047];
   logic [43:0] obs_q [$];
   int          obs_cyc [$];
   int          w_pend = 0;
   int          r_pend = 0;
   logic [10:0] r_addr_l = '0;

   always @(negedge up_clk) begin
      m_up_wack = 1'b0;
      m_up_rack = 1'b0;
      if (w_pend > 0) begin
         w_pend--;
         if (w_pend == 0) m_up_wack = 1'b1;
      end
      if (r_pend > 0) begin
         r_pend--;
         if (r_pend == 0) begin
            m_up_rack  = 1'b1;
            m_up_rdata = rd_ovr_en ? rd_ovr_val : mem[r_addr_l];
         end
      end
      if (inject_req != inject_done) begin
         m_up_wack = 1'b1;
         inject_done++;
      end
      if (m_up_wreq) begin
         obs_q.push_back({1'b1, m_up_waddr, m_up_wdata});
         obs_cyc.push_back(cyc);
         mem[m_up_waddr] = m_up_wdata;
         if (!(drop_en && m_up_waddr == drop_addr)) w_pend = lat;
      end
      if (m_up_rreq) begin
         obs_q.push_back({1'b0, m_up_raddr, 32'h0});
         obs_cyc.push_back(cyc);
         r_addr_l = m_up_raddr;
         r_pend   = lat;
      end
   end

   int          done_cnt = 0;
   int          done_cyc = 0;
   int          wack_cnt = 0;
   int          rack_cnt = 0;
   int          busy_cyc = 0;
   logic [31:0] last_rdata = '0;

   always @(negedge up_clk) begin
      #1;
      if (seq_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (s_up_wack) wack_cnt++;
      if (s_up_rack) begin
         rack_cnt++;
         last_rdata = s_up_rdata;
      end
      if (seq_busy) busy_cyc++;
   end

   logic [43:0] exp_q [$];
   logic [31:0] shadow [logic [10:0]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected regmap traffic of one profile switch, straight from the register map.
   task automatic push_seq(input int p, input logic [NCH*4-1:0] s, input bit full);
      exp_q.push_back({1'b1, 11'h010, 32'h0});
      exp_q.push_back({1'b1, 11'h091, 32'(p)});
      if (full) begin
         for (int ch = 0; ch < NCH; ch++)
            exp_q.push_back({1'b1, 11'((256 + 16 * ch + 6) % 2048), 32'((s >> (4 * ch)) & 15)});
         exp_q.push_back({1'b1, 11'h010, 32'h3});
         exp_q.push_back({1'b0, 11'h091, 32'h0});
      end
   endtask

   task automatic compare_log(input int base, input string tag);
      check($sformatf("%s_len", tag), 64'(obs_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < obs_q.size())
            check($sformatf("%s_txn%0d", tag, i), 64'(obs_q[base + i]), 64'(exp_q[i]));
      exp_q.delete();
   endtask

   task automatic start_seq(input int p, input logic [NCH*4-1:0] s);
      @(negedge up_clk);
      seq_req      = 1'b1;
      seq_profile  = PW'(p);
      seq_data_sel = s;
      @(negedge up_clk);
      seq_req      = 1'b0;
      seq_profile  = ~PW'(p);
      seq_data_sel = NCH*4'($urandom);
   endtask

   task automatic wait_done(input int d0, input int budget, input string tag);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge up_clk);
         #2;
         n++;
      end
      check(tag, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic ext_wr(input logic [10:0] a, input logic [31:0] d, input string tag);
      int w0, n;
      w0 = wack_cnt;
      @(negedge up_clk);
      s_up_wreq  = 1'b1;
      s_up_waddr = a;
      s_up_wdata = d;
      @(negedge up_clk);
      s_up_wreq = 1'b0;
      n = 0;
      while (wack_cnt == w0 && n < 50) begin
         @(negedge up_clk);
         #2;
         n++;
      end
      check(tag, 64'(wack_cnt - w0), 64'd1);
      shadow[a] = d;
   endtask

   task automatic ext_rd(input logic [10:0] a, input string tag);
      int r0, n;
      r0 = rack_cnt;
      @(negedge up_clk);
      s_up_rreq  = 1'b1;
      s_up_raddr = a;
      @(negedge up_clk);
      s_up_rreq = 1'b0;
      n = 0;
      while (rack_cnt == r0 && n < 50) begin
         @(negedge up_clk);
         #2;
         n++;
      end
      check({tag, "_ack"}, 64'(rack_cnt - r0), 64'd1);
      check({tag, "_data"}, 64'(last_rdata), 64'(shadow[a]));
   endtask

   initial begin
      int          base, d0, w0, r0, b0, n, p;
      logic [NCH*4-1:0] s;
      logic [10:0] a1, a2;
      logic [31:0] d1, d2;

      // Reset state
      repeat (3) @(negedge up_clk);
      #2;
      check("rst_ctrl", 64'({seq_busy, seq_done, seq_error, seq_error_code,
                             m_up_wreq, m_up_rreq, s_up_wack, s_up_rack}), 64'd0);
      check("rst_bus", 64'({m_up_waddr, m_up_wdata, m_up_raddr}), 64'd0);
      check("rst_rdata", 64'(s_up_rdata), 64'd0);
      @(negedge up_clk);
      up_rst = 1'b0;
      repeat (2) @(negedge up_clk);

      // Directed profile switch
      lat  = 2;
      base = obs_q.size();
      d0   = done_cnt;
      start_seq(1, 8'h2B);
      #2;
      check("busy_rise", 64'(seq_busy), 64'd1);
      wait_done(d0, 100, "dir_done");
      check("dir_busy_at_done", 64'(seq_busy), 64'd0);
      repeat (4) @(negedge up_clk);
      #2;
      check("dir_done_once", 64'(done_cnt - d0), 64'd1);
      check("dir_err", 64'({seq_error, seq_error_code}), 64'd0);
      push_seq(1, 8'h2B, 1'b1);
      compare_log(base, "dir");

      // Randomized profile switches with varying regmap latency
      for (int k = 0; k < 4; k++) begin
         lat  = $urandom_range(1, 4);
         p    = $urandom_range(0, 1);
         s    = NCH*4'($urandom);
         base = obs_q.size();
         d0   = done_cnt;
         start_seq(p, s);
         wait_done(d0, 200, $sformatf("rnd%0d_done", k));
         repeat (3) @(negedge up_clk);
         #2;
         check($sformatf("rnd%0d_err", k), 64'({seq_error, seq_error_code}), 64'd0);
         push_seq(p, s, 1'b1);
         compare_log(base, $sformatf("rnd%0d", k));
      end

      // External write colliding with seq_req: sequence first, write afterwards
      lat  = 2;
      d1   = $urandom;
      base = obs_q.size();
      d0   = done_cnt;
      w0   = wack_cnt;
      @(negedge up_clk);
      seq_req      = 1'b1;
      seq_profile  = 1'b1;
      seq_data_sel = 8'h5C;
      s_up_wreq    = 1'b1;
      s_up_waddr   = 11'h118;
      s_up_wdata   = d1;
      @(negedge up_clk);
      seq_req   = 1'b0;
      s_up_wreq = 1'b0;
      wait_done(d0, 100, "coll_done");
      check("coll_wack_before_fin", 64'(wack_cnt - w0), 64'd0);
      repeat (10) @(negedge up_clk);
      #2;
      check("coll_wack_once", 64'(wack_cnt - w0), 64'd1);
      push_seq(1, 8'h5C, 1'b1);
      exp_q.push_back({1'b1, 11'h118, d1});
      compare_log(base, "coll");
      shadow[11'h118] = d1;

      // Regmap never acks the profile write
      a1 = 11'h2A0;
      ext_wr(a1, 32'hCAFE_0001, "pre_tmo_wr");
      drop_en = 1'b1;
      base = obs_q.size();
      d0   = done_cnt;
      start_seq(1, 8'h31);
      wait_done(d0, 400, "tmo_done");
      drop_en = 1'b0;
      check("tmo_code", 64'({seq_error, seq_error_code}), 64'({1'b1, 2'd1}));
      if (obs_q.size() > base + 1)
         check("tmo_latency_band", 64'((done_cyc - obs_cyc[base + 1]) >= 255 &&
                                        (done_cyc - obs_cyc[base + 1]) <= 262), 64'd1);
      else
         check("tmo_prof_seen", 64'(obs_q.size() - base), 64'd2);
      w0 = wack_cnt;
      inject_req++;
      repeat (5) @(negedge up_clk);
      #2;
      check("tmo_late_wack_ignored", 64'(wack_cnt - w0), 64'd0);
      push_seq(1, 8'h31, 1'b0);
      compare_log(base, "tmo");
      check("tmo_err_sticky", 64'(seq_error), 64'd1);
      ext_rd(a1, "post_tmo_rd");

      // Readback mismatch
      rd_ovr_en  = 1'b1;
      rd_ovr_val = 32'h0;
      base = obs_q.size();
      d0   = done_cnt;
      start_seq(1, 8'h76);
      #2;
      check("mis_err_cleared", 64'(seq_error), 64'd0);
      wait_done(d0, 100, "mis_done");
      rd_ovr_en = 1'b0;
      check("mis_code", 64'({seq_error, seq_error_code}), 64'({1'b1, 2'd2}));
      push_seq(1, 8'h76, 1'b1);
      compare_log(base, "mis");

      // Reset during per-channel programming
      lat  = 3;
      base = obs_q.size();
      d0   = done_cnt;
      start_seq(0, 8'hE9);
      n = 0;
      while (obs_q.size() < base + 3 && n < 100) begin
         @(negedge up_clk);
         n++;
      end
      check("rst_mid_reached_sel", 64'(obs_q.size() >= base + 3), 64'd1);
      up_rst = 1'b1;
      @(negedge up_clk);
      #2;
      check("rst_mid_outputs", 64'({seq_busy, seq_done, seq_error, seq_error_code,
                                    m_up_wreq, m_up_rreq, s_up_wack, s_up_rack}), 64'd0);
      up_rst = 1'b0;
      n = obs_q.size();
      repeat (20) @(negedge up_clk);
      #2;
      check("rst_mid_no_traffic", 64'(obs_q.size() - n), 64'd0);
      check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
      base = obs_q.size();
      d0   = done_cnt;
      start_seq(1, 8'h4D);
      wait_done(d0, 100, "after_rst_done");
      check("after_rst_err", 64'({seq_error, seq_error_code}), 64'd0);
      push_seq(1, 8'h4D, 1'b1);
      compare_log(base, "after_rst");

      // Plain pass-through, no sequence
      lat = 2;
      b0  = busy_cyc;
      for (int k = 0; k < 3; k++) begin
         a2 = 11'($urandom_range(11'h200, 11'h7FF));
         d2 = $urandom;
         ext_wr(a2, d2, $sformatf("pt%0d_wr", k));
         ext_rd(a2, $sformatf("pt%0d_rd", k));
      end
      a2   = 11'h3F0;
      d2   = $urandom;
      base = obs_q.size();
      w0   = wack_cnt;
      r0   = rack_cnt;
      @(negedge up_clk);
      s_up_wreq  = 1'b1;
      s_up_waddr = a2;
      s_up_wdata = d2;
      s_up_rreq  = 1'b1;
      s_up_raddr = a1;
      @(negedge up_clk);
      s_up_wreq = 1'b0;
      s_up_rreq = 1'b0;
      repeat (15) @(negedge up_clk);
      #2;
      check("pt_both_wack", 64'(wack_cnt - w0), 64'd1);
      check("pt_both_rack", 64'(rack_cnt - r0), 64'd1);
      check("pt_both_rdata", 64'(last_rdata), 64'(shadow[a1]));
      exp_q.push_back({1'b1, a2, d2});
      exp_q.push_back({1'b0, a1, 32'h0});
      compare_log(base, "pt_both");
      check("pt_no_busy", 64'(busy_cyc - b0), 64'd0);
      check("total_done", 64'(done_cnt), 64'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
